// File: rtl/sha_uart_pkg.sv
// sha_uart_pkg: shared states and constants for the UART-to-SHA-256 block sequencer
package sha_uart_pkg;
    localparam int CLKS_PER_BIT  = 868;
    localparam int TIMEOUT_CLKS  = 20 * CLKS_PER_BIT;
    localparam int MAX_MSG_BYTES = 55;
    localparam int BLOCK_WORDS   = 16;
    localparam int DIGEST_BYTES  = 32;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_PAD,
        S_START,
        S_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_t;
endpackage

// File: rtl/sha_uart_ctrl_if.sv
// sha_uart_ctrl_if: UART RX/TX and SHA-core handshake bundle for the sequencer
interface sha_uart_ctrl_if;
    logic         Rx_DV_in;
    logic [7:0]   Rx_Byte_in;
    logic         Sha_Wr_out;
    logic [3:0]   Sha_Addr_out;
    logic [31:0]  Sha_Word_out;
    logic         Sha_Start_out;
    logic         Sha_Done_in;
    logic [255:0] Sha_Digest_in;
    logic         Tx_DV_out;
    logic [7:0]   Tx_Byte_out;
    logic         Tx_Busy_in;
    logic         Tx_Done_in;
    logic         Busy_out;
    logic         Err_out;

    modport master (
        input  Rx_DV_in, Rx_Byte_in, Sha_Done_in, Sha_Digest_in, Tx_Busy_in, Tx_Done_in,
        output Sha_Wr_out, Sha_Addr_out, Sha_Word_out, Sha_Start_out, Tx_DV_out, Tx_Byte_out,
               Busy_out, Err_out
    );

    modport slave (
        output Rx_DV_in, Rx_Byte_in, Sha_Done_in, Sha_Digest_in, Tx_Busy_in, Tx_Done_in,
        input  Sha_Wr_out, Sha_Addr_out, Sha_Word_out, Sha_Start_out, Tx_DV_out, Tx_Byte_out,
               Busy_out, Err_out
    );
endinterface

// File: rtl/sha_pad_word.sv
// sha_pad_word: one big-endian word k of the padded single 512-bit block for an n-byte message
module sha_pad_word
    import sha_uart_pkg::*;
(
    input  logic [7:0]  msg [MAX_MSG_BYTES],
    input  logic [5:0]  n,
    input  logic [3:0]  k,
    output logic [31:0] word
);
    logic [15:0] bit_len;

    assign bit_len = {7'd0, n, 3'd0};

    for (genvar b = 0; b < 4; b++) begin : g_byte
        logic [5:0] i;
        assign i = {k, 2'(b)};
        assign word[31 - 8 * b -: 8] = (i < n)       ? msg[i] :
                                       (i == n)      ? PAD_BYTE :
                                       (i == 6'd62)  ? bit_len[15:8] :
                                       (i == 6'd63)  ? bit_len[7:0] : 8'h00;
    end
endmodule

// File: rtl/sha_uart_ctrl.sv
// sha_uart_ctrl: receives a length-prefixed message over UART, pads it into one SHA-256 block,
// runs the core and streams the 32-byte digest back out. Optional RX_TIMEOUT_EN aborts a
// message whose bytes stop arriving for TIMEOUT_CLKS cycles.
module sha_uart_ctrl
    import sha_uart_pkg::*;
(
    input logic CLK,
    input logic rst_n,
    sha_uart_ctrl_if.master bus
);
    state_t       state;
    logic [5:0]   n;
    logic [5:0]   cnt;
    logic [4:0]   j;
    logic [255:0] digest;
    logic [7:0]   msg [MAX_MSG_BYTES];
    logic [31:0]  pad_word;
`ifdef RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    logic [IW-1:0] idle_cnt;
`endif

    sha_pad_word u_pad (.msg(msg), .n(n), .k(bus.Sha_Addr_out), .word(pad_word));

    assign bus.Sha_Word_out = bus.Sha_Wr_out ? pad_word : 32'd0;
    assign bus.Busy_out     = state != S_IDLE;

    // Message buffer; only bytes below the recorded length are ever read, so no reset needed
    always_ff @(posedge CLK)
        if (state == S_RECV && bus.Rx_DV_in) msg[cnt] <= bus.Rx_Byte_in;

    // Sequencer: length parse, receive, 16-word block write, start, digest wait, byte-wise TX
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            n                 <= '0;
            cnt               <= '0;
            j                 <= '0;
            digest            <= '0;
            bus.Sha_Wr_out    <= 1'b0;
            bus.Sha_Addr_out  <= '0;
            bus.Sha_Start_out <= 1'b0;
            bus.Tx_DV_out     <= 1'b0;
            bus.Tx_Byte_out   <= '0;
            bus.Err_out       <= 1'b0;
`ifdef RX_TIMEOUT_EN
            idle_cnt          <= '0;
`endif
        end else begin
            bus.Sha_Start_out <= 1'b0;
            bus.Tx_DV_out     <= 1'b0;
`ifdef RX_TIMEOUT_EN
            idle_cnt <= (state != S_RECV || bus.Rx_DV_in) ? '0 : idle_cnt + 1'b1;
`endif
            case (state)
                S_IDLE:
                    if (bus.Rx_DV_in) begin
                        if (bus.Rx_Byte_in <= 8'(MAX_MSG_BYTES)) begin
                            n           <= bus.Rx_Byte_in[5:0];
                            cnt         <= '0;
                            bus.Err_out <= 1'b0;
                            if (bus.Rx_Byte_in == 8'd0) begin
                                state            <= S_PAD;
                                bus.Sha_Wr_out   <= 1'b1;
                                bus.Sha_Addr_out <= '0;
                            end else begin
                                state <= S_RECV;
                            end
                        end else begin
                            bus.Err_out <= 1'b1;
                        end
                    end
                S_RECV:
                    if (bus.Rx_DV_in) begin
                        cnt <= cnt + 6'd1;
                        if (cnt + 6'd1 == n) begin
                            state            <= S_PAD;
                            bus.Sha_Wr_out   <= 1'b1;
                            bus.Sha_Addr_out <= '0;
                        end
                    end
`ifdef RX_TIMEOUT_EN
                    else if (idle_cnt == IW'(TIMEOUT_CLKS)) begin
                        bus.Err_out <= 1'b1;
                        state       <= S_IDLE;
                    end
`endif
                S_PAD:
                    if (bus.Sha_Addr_out == 4'(BLOCK_WORDS - 1)) begin
                        bus.Sha_Wr_out    <= 1'b0;
                        bus.Sha_Addr_out  <= '0;
                        bus.Sha_Start_out <= 1'b1;
                        state             <= S_START;
                    end else begin
                        bus.Sha_Addr_out <= bus.Sha_Addr_out + 4'd1;
                    end
                S_START:
                    state <= S_WAIT;
                S_WAIT:
                    if (bus.Sha_Done_in) begin
                        digest <= bus.Sha_Digest_in;
                        j      <= '0;
                        state  <= S_TX_LOAD;
                    end
                S_TX_LOAD:
                    if (!bus.Tx_Busy_in) begin
                        bus.Tx_DV_out   <= 1'b1;
                        bus.Tx_Byte_out <= digest[{~j, 3'b111} -: 8];
                        state           <= S_TX_WAIT;
                    end
                S_TX_WAIT:
                    if (bus.Tx_Done_in) begin
                        j     <= j + 5'd1;
                        state <= (j == 5'(DIGEST_BYTES - 1)) ? S_IDLE : S_TX_LOAD;
                    end
                default:
                    state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_uart_ctrl.sv
// tb_sha_uart_ctrl: directed bench with a behavioural SHA core and a 10-clock UART TX model
module tb_sha_uart_ctrl;
    import sha_uart_pkg::*;

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_OTHER = {8{32'h5a5ac3c3}};

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    sha_uart_ctrl_if bus();
    sha_uart_ctrl dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

    always #5 CLK = ~CLK;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int rx_cyc = 0;
    int wr_cnt = 0;
    int first_wr_cyc = -1;
    int last_wr_cyc = -1;
    int start_cyc = -1;
    int sha_left = 0;
    int tx_left = 0;
    logic [31:0]  words [16];
    logic [7:0]   txq [$];
    logic         sha_done_m = 1'b0;
    logic [255:0] sha_dig_m = '0;
    logic         tx_busy_m = 1'b0;
    logic         tx_done_m = 1'b0;
    logic         hold_busy = 1'b0;

    assign bus.Sha_Done_in   = sha_done_m;
    assign bus.Sha_Digest_in = sha_dig_m;
    assign bus.Tx_Busy_in    = tx_busy_m | hold_busy;
    assign bus.Tx_Done_in    = tx_done_m;

    always @(posedge CLK) cyc <= cyc + 1;

    // Block-write logger plus SHA core model: done 5 cycles after start, digest chosen by word 0
    always @(negedge CLK) begin
        sha_done_m = 1'b0;
        if (bus.Sha_Wr_out) begin
            words[bus.Sha_Addr_out] = bus.Sha_Word_out;
            wr_cnt++;
            if (bus.Sha_Addr_out == 4'd0) first_wr_cyc = cyc;
            if (bus.Sha_Addr_out == 4'd15) last_wr_cyc = cyc;
        end
        if (!rst_n) sha_left = 0;
        else if (bus.Sha_Start_out) begin
            start_cyc = cyc;
            sha_left = 5;
        end else if (sha_left > 0) begin
            sha_left--;
            if (sha_left == 0) begin
                sha_done_m = 1'b1;
                sha_dig_m = (words[0] == 32'h61626380) ? DIG_ABC :
                            (words[0] == 32'h80000000) ? DIG_EMPTY : DIG_OTHER;
            end
        end
    end

    // UART transmitter model: 10-clock frame, done strobe at the end
    always @(negedge CLK) begin
        tx_done_m = 1'b0;
        if (!rst_n) begin
            tx_busy_m = 1'b0;
            tx_left = 0;
        end else if (bus.Tx_DV_out) begin
            txq.push_back(bus.Tx_Byte_out);
            tx_busy_m = 1'b1;
            tx_left = 10;
        end else if (tx_busy_m) begin
            tx_left--;
            if (tx_left == 0) begin
                tx_busy_m = 1'b0;
                tx_done_m = 1'b1;
            end
        end
    end

    function automatic logic [255:0] tx_bytes(input int base);
        logic [255:0] d = '0;
        for (int i = 0; i < 32; i++) d = {d[247:0], (base + i < txq.size()) ? txq[base + i] : 8'h00};
        return d;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.Rx_DV_in = 1'b1;
        bus.Rx_Byte_in = b;
        rx_cyc = cyc;
        @(negedge CLK);
        bus.Rx_DV_in = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_abc();
        send_byte(8'h03);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
    endtask

    task automatic wait_idle(output logic ok);
        for (int i = 0; i < 3000 && bus.Busy_out; i++) @(negedge CLK);
        ok = !bus.Busy_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        n_total++;
        if ({bus.Sha_Wr_out, bus.Sha_Start_out, bus.Tx_DV_out, bus.Busy_out, bus.Err_out} !== 5'b0)
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.Sha_Wr_out, bus.Sha_Start_out, bus.Tx_DV_out, bus.Busy_out, bus.Err_out});
        else n_pass++;
        n_total++;
        if ({bus.Sha_Addr_out, bus.Sha_Word_out, bus.Tx_Byte_out} !== 44'd0)
            $display("FAIL reset_buses: got %h, required 0", {bus.Sha_Addr_out, bus.Sha_Word_out, bus.Tx_Byte_out});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        n_total++;
        if (bus.Busy_out !== 1'b0) $display("FAIL reset_release_busy: got %b, required 0", bus.Busy_out);
        else n_pass++;
    endtask

    task automatic test_abc();
        int base = txq.size();
        int wb = wr_cnt;
        logic ok;
        logic [31:0] orw = '0;
        logic [255:0] d;
        send_abc();
        wait_idle(ok);
        d = tx_bytes(base);
        for (int i = 1; i < 15; i++) orw |= words[i];
        n_total++;
        if (ok !== 1'b1) $display("FAIL abc_done: still busy, required idle within 3000 cycles");
        else n_pass++;
        n_total++;
        if (words[0] !== 32'h61626380) $display("FAIL abc_word0: got %h, required 61626380", words[0]);
        else n_pass++;
        n_total++;
        if (orw !== 32'd0) $display("FAIL abc_words1_14: OR got %h, required 00000000", orw);
        else n_pass++;
        n_total++;
        if (words[15] !== 32'h00000018) $display("FAIL abc_word15: got %h, required 00000018", words[15]);
        else n_pass++;
        n_total++;
        if (wr_cnt - wb != 16) $display("FAIL abc_wr_count: got %0d, required 16", wr_cnt - wb);
        else n_pass++;
        n_total++;
        if (first_wr_cyc != rx_cyc + 1) $display("FAIL abc_wr_latency: got %0d, required %0d", first_wr_cyc - rx_cyc, 1);
        else n_pass++;
        n_total++;
        if (start_cyc != rx_cyc + 17 || last_wr_cyc != rx_cyc + 16)
            $display("FAIL abc_start_latency: start %0d last_wr %0d, required 17 and 16",
                     start_cyc - rx_cyc, last_wr_cyc - rx_cyc);
        else n_pass++;
        n_total++;
        if (txq.size() - base != 32) $display("FAIL abc_tx_count: got %0d, required 32", txq.size() - base);
        else n_pass++;
        n_total++;
        if (d[255:248] !== 8'hBA || d[7:0] !== 8'hAD)
            $display("FAIL abc_tx_ends: got %h..%h, required ba..ad", d[255:248], d[7:0]);
        else n_pass++;
        n_total++;
        if (d !== DIG_ABC) $display("FAIL abc_digest: got %h, required %h", d, DIG_ABC);
        else n_pass++;
        n_total++;
        if (bus.Err_out !== 1'b0) $display("FAIL abc_err: got %b, required 0", bus.Err_out);
        else n_pass++;
    endtask

    task automatic test_empty();
        int base = txq.size();
        logic ok;
        logic [31:0] orw = '0;
        send_byte(8'h00);
        wait_idle(ok);
        for (int i = 1; i < 16; i++) orw |= words[i];
        n_total++;
        if (ok !== 1'b1) $display("FAIL empty_done: still busy, required idle within 3000 cycles");
        else n_pass++;
        n_total++;
        if (words[0] !== 32'h80000000) $display("FAIL empty_word0: got %h, required 80000000", words[0]);
        else n_pass++;
        n_total++;
        if (orw !== 32'd0) $display("FAIL empty_words1_15: OR got %h, required 00000000", orw);
        else n_pass++;
        n_total++;
        if (start_cyc != rx_cyc + 17) $display("FAIL empty_start_latency: got %0d, required 17", start_cyc - rx_cyc);
        else n_pass++;
        n_total++;
        if (tx_bytes(base) !== DIG_EMPTY) $display("FAIL empty_digest: got %h, required %h", tx_bytes(base), DIG_EMPTY);
        else n_pass++;
    endtask

    task automatic test_max();
        int base = txq.size();
        logic ok;
        send_byte(8'h37);
        for (int i = 0; i < 55; i++) send_byte(8'h41);
        wait_idle(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL max_done: still busy, required idle within 3000 cycles");
        else n_pass++;
        n_total++;
        if (words[0] !== 32'h41414141) $display("FAIL max_word0: got %h, required 41414141", words[0]);
        else n_pass++;
        n_total++;
        if (words[13] !== 32'h41414180) $display("FAIL max_word13: got %h, required 41414180", words[13]);
        else n_pass++;
        n_total++;
        if (words[14] !== 32'h00000000) $display("FAIL max_word14: got %h, required 00000000", words[14]);
        else n_pass++;
        n_total++;
        if (words[15] !== 32'h000001B8) $display("FAIL max_word15: got %h, required 000001b8", words[15]);
        else n_pass++;
        n_total++;
        if (tx_bytes(base) !== DIG_OTHER) $display("FAIL max_digest: got %h, required %h", tx_bytes(base), DIG_OTHER);
        else n_pass++;
    endtask

    task automatic test_err();
        int base;
        int wb = wr_cnt;
        logic ok;
        send_byte(8'h38);
        n_total++;
        if (bus.Err_out !== 1'b1 || bus.Busy_out !== 1'b0)
            $display("FAIL err_len56: err %b busy %b, required err 1 busy 0", bus.Err_out, bus.Busy_out);
        else n_pass++;
        send_byte(8'hFF);
        n_total++;
        if (bus.Err_out !== 1'b1 || bus.Busy_out !== 1'b0)
            $display("FAIL err_len255: err %b busy %b, required err 1 busy 0", bus.Err_out, bus.Busy_out);
        else n_pass++;
        n_total++;
        if (wr_cnt != wb) $display("FAIL err_no_write: got %0d writes, required 0", wr_cnt - wb);
        else n_pass++;
        base = txq.size();
        send_byte(8'h03);
        n_total++;
        if (bus.Err_out !== 1'b0 || bus.Busy_out !== 1'b1)
            $display("FAIL err_clear: err %b busy %b, required err 0 busy 1", bus.Err_out, bus.Busy_out);
        else n_pass++;
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        wait_idle(ok);
        n_total++;
        if (ok !== 1'b1 || words[0] !== 32'h61626380)
            $display("FAIL err_recover_word0: idle %b word0 %h, required 1 and 61626380", ok, words[0]);
        else n_pass++;
        n_total++;
        if (tx_bytes(base) !== DIG_ABC) $display("FAIL err_recover_digest: got %h, required %h", tx_bytes(base), DIG_ABC);
        else n_pass++;
    endtask

    task automatic test_tx_busy_reset();
        int base = txq.size();
        int qn;
        int got;
        hold_busy = 1'b1;
        send_abc();
        repeat (40) @(negedge CLK);
        got = txq.size() - base;
        n_total++;
        if (got != 0 || bus.Busy_out !== 1'b1)
            $display("FAIL txbusy_hold: got %0d bytes busy %b, required 0 bytes busy 1", got, bus.Busy_out);
        else n_pass++;
        hold_busy = 1'b0;
        for (int i = 0; i < 300 && txq.size() < base + 3; i++) @(negedge CLK);
        got = txq.size() - base;
        n_total++;
        if (got < 3 || tx_bytes(base) >> 232 !== 256'hBA7816)
            $display("FAIL txbusy_release: got %0d bytes head %h, required >=3 bytes head ba7816", got, tx_bytes(base) >> 232);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.Sha_Wr_out, bus.Sha_Start_out, bus.Tx_DV_out, bus.Busy_out, bus.Err_out} !== 5'b0)
            $display("FAIL midtx_reset_flags: got %b, required 00000",
                     {bus.Sha_Wr_out, bus.Sha_Start_out, bus.Tx_DV_out, bus.Busy_out, bus.Err_out});
        else n_pass++;
        n_total++;
        if ({bus.Sha_Addr_out, bus.Sha_Word_out, bus.Tx_Byte_out} !== 44'd0)
            $display("FAIL midtx_reset_buses: got %h, required 0", {bus.Sha_Addr_out, bus.Sha_Word_out, bus.Tx_Byte_out});
        else n_pass++;
        qn = txq.size();
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        repeat (20) @(negedge CLK);
        n_total++;
        if (bus.Busy_out !== 1'b0 || txq.size() != qn)
            $display("FAIL midtx_after_release: busy %b extra bytes %0d, required busy 0 and 0", bus.Busy_out, txq.size() - qn);
        else n_pass++;
    endtask

`ifdef RX_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        int wb = wr_cnt;
        logic ok;
        send_byte(8'h05);
        send_byte(8'h61);
        send_byte(8'h62);
        repeat (TIMEOUT_CLKS + 20) @(negedge CLK);
        n_total++;
        if (bus.Err_out !== 1'b1 || bus.Busy_out !== 1'b0 || wr_cnt != wb)
            $display("FAIL timeout_abort: err %b busy %b writes %0d, required err 1 busy 0 writes 0",
                     bus.Err_out, bus.Busy_out, wr_cnt - wb);
        else n_pass++;
        base = txq.size();
        send_abc();
        wait_idle(ok);
        n_total++;
        if (ok !== 1'b1 || tx_bytes(base) !== DIG_ABC || bus.Err_out !== 1'b0)
            $display("FAIL timeout_recover: idle %b err %b digest %h, required 1 0 %h", ok, bus.Err_out, tx_bytes(base), DIG_ABC);
        else n_pass++;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        bus.Rx_DV_in = 1'b0;
        bus.Rx_Byte_in = 8'h00;
        test_reset();
        test_abc();
        test_empty();
        test_max();
        test_err();
        test_tx_busy_reset();
`ifdef RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
